// File: rtl/output_writer.sv
// Output writer: packs post/pooling beats into memory words, buffers them in a FIFO and
// streams them out with a row/column address. Define OUTPUT_WRITER_ROW_STRIDE_EN for strided rows.
module output_writer #(
   parameter int POX        = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  cfg_pool_en,
   input  logic [ADDR_W-1:0]     cfg_base_addr,
   input  logic [ADDR_W-1:0]     cfg_row_words,
   input  logic [ADDR_W-1:0]     cfg_rows,
   input  logic [ADDR_W-1:0]     cfg_row_stride,
   input  logic [POX*16-1:0]     post_out,
   input  logic                  post_out_valid,
   input  logic [POX/2*16-1:0]   pooling_out,
   input  logic                  pooling_out_valid,
   output logic                  mem_wr_en,
   output logic [ADDR_W-1:0]     mem_wr_addr,
   output logic [POX*16-1:0]     mem_wr_data,
   input  logic                  mem_wr_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   localparam int DW = POX * 16;
   localparam int HW = POX / 2 * 16;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = 2 * ADDR_W;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            r_state;
   logic [DW-1:0]     r_fifo [FIFO_DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;
   logic              r_half_valid;
   logic [HW-1:0]     r_half_data;
   logic [CW-1:0]     r_total;
   logic [CW-1:0]     r_accepted;
   logic              r_pool_en;
   logic              r_overflow;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_row_words;
   logic [ADDR_W-1:0] r_col;
   logic [ADDR_W-1:0] r_row;
   logic [ADDR_W-1:0] r_xfer;

   logic              w_active;
   logic              w_en;
   logic              w_pop;
   logic              w_accepting;
   logic              w_word_valid;
   logic [DW-1:0]     w_word;
   logic              w_room;
   logic              w_push;
   logic              w_drop;
   logic [CW-1:0]     w_acc_next;
   logic              w_last_col;
   logic [ADDR_W-1:0] w_addr;

   assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign w_en        = w_active && (r_count != '0);
   assign w_pop       = w_en && mem_wr_ready;
   assign w_accepting = (r_state == S_RUN) && (r_accepted != r_total);

   always_comb begin
      w_word_valid = 1'b0;
      w_word       = post_out;
      if (w_accepting) begin
         if (r_pool_en) begin
            w_word       = {pooling_out, r_half_data};
            w_word_valid = pooling_out_valid && r_half_valid;
         end else begin
            w_word_valid = post_out_valid;
         end
      end
   end

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign w_room     = (r_count != DEPTH_C) || w_pop;
   assign w_push     = w_word_valid && w_room;
   assign w_drop     = w_word_valid && !w_room;
   assign w_acc_next = r_accepted + CW'(w_push);
   assign w_last_col = (r_col == r_row_words - 1'b1);

`ifdef OUTPUT_WRITER_ROW_STRIDE_EN
   logic [ADDR_W-1:0] r_stride;
   logic              w_unused_bits;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stride <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_stride <= cfg_row_stride;
      end
   end

   assign w_addr        = r_base + r_row * r_stride + r_col;
   assign w_unused_bits = ^r_xfer;
`else
   logic w_unused_bits;

   assign w_addr        = r_base + r_xfer;
   assign w_unused_bits = ^{cfg_row_stride, r_row};
`endif

   assign mem_wr_en   = w_en;
   assign mem_wr_addr = w_en ? w_addr : '0;
   assign mem_wr_data = w_en ? r_fifo[r_rptr] : '0;
   assign busy        = w_active;
   assign done        = (r_state == S_DONE);
   assign overflow    = r_overflow;

   // Storage needs no reset: the head is only visible while the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wptr] <= w_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_half_valid <= 1'b0;
         r_half_data  <= '0;
         r_total      <= '0;
         r_accepted   <= '0;
         r_pool_en    <= 1'b0;
         r_overflow   <= 1'b0;
         r_base       <= '0;
         r_row_words  <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_xfer       <= '0;
      end else begin
         r_accepted <= w_acc_next;

         if (w_accepting && r_pool_en && pooling_out_valid) begin
            if (r_half_valid) begin
               r_half_valid <= 1'b0;
            end else begin
               r_half_valid <= 1'b1;
               r_half_data  <= pooling_out;
            end
         end

         if (w_drop) begin
            r_overflow <= 1'b1;
         end

         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end

         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
            r_xfer <= r_xfer + 1'b1;
            if (w_last_col) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_pool_en    <= cfg_pool_en;
                  r_base       <= cfg_base_addr;
                  r_row_words  <= cfg_row_words;
                  r_total      <= CW'(cfg_rows) * CW'(cfg_row_words);
                  r_accepted   <= '0;
                  r_col        <= '0;
                  r_row        <= '0;
                  r_xfer       <= '0;
                  r_half_valid <= 1'b0;
                  r_overflow   <= 1'b0;
                  r_state      <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_acc_next == r_total) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (r_count == '0) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_output_writer.sv
// Directed bench for output_writer: a queue-based job model checked every cycle plus
// literal expectations on the logged write stream.
module tb_output_writer;

   localparam int POX        = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int ADDR_W     = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        cfg_pool_en = 1'b0;
   logic [15:0] cfg_base_addr = '0;
   logic [15:0] cfg_row_words = '0;
   logic [15:0] cfg_rows = '0;
   logic [15:0] cfg_row_stride = '0;
   logic [63:0] post_out = '0;
   logic        post_out_valid = 1'b0;
   logic [31:0] pooling_out = '0;
   logic        pooling_out_valid = 1'b0;
   logic        mem_wr_en;
   logic [15:0] mem_wr_addr;
   logic [63:0] mem_wr_data;
   logic        mem_wr_ready = 1'b1;
   logic        busy;
   logic        done;
   logic        overflow;

   output_writer #(.POX(POX), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_pool_en(cfg_pool_en),
      .cfg_base_addr(cfg_base_addr), .cfg_row_words(cfg_row_words),
      .cfg_rows(cfg_rows), .cfg_row_stride(cfg_row_stride),
      .post_out(post_out), .post_out_valid(post_out_valid),
      .pooling_out(pooling_out), .pooling_out_valid(pooling_out_valid),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_ready(mem_wr_ready), .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [15:0] log_a[$];
   logic [63:0] log_d[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Job model: queue of stored words, job-level accepted/transfer counts.
   bit          m_busy, m_done, m_ovf, m_half, m_pool;
   logic [31:0] m_half_d;
   logic [63:0] q[$];
   int unsigned m_total, m_acc, m_xfer, m_base, m_rw, m_stride;

   function automatic logic [15:0] m_addr(input int unsigned k);
`ifdef OUTPUT_WRITER_ROW_STRIDE_EN
      return 16'(m_base + (k / m_rw) * m_stride + (k % m_rw));
`else
      return 16'(m_base + k);
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      bit          pop, room, have;
      logic [63:0] w;
      if (rst) begin
         m_busy = 0; m_done = 0; m_ovf = 0; m_half = 0; m_pool = 0;
         m_acc = 0; m_total = 0; m_xfer = 0;
         q.delete();
      end else begin
         pop  = m_busy && (q.size() > 0) && mem_wr_ready;
         room = (q.size() < FIFO_DEPTH) || pop;
         have = 0;
         w    = post_out;
         if (m_busy && m_acc < m_total) begin
            if (m_pool) begin
               if (pooling_out_valid) begin
                  if (m_half) begin
                     have = 1; w = {pooling_out, m_half_d}; m_half = 0;
                  end else begin
                     m_half = 1; m_half_d = pooling_out;
                  end
               end
            end else if (post_out_valid) begin
               have = 1;
            end
         end
         if (m_done) begin
            m_done = 0;
         end else if (m_busy && m_acc == m_total && q.size() == 0) begin
            m_busy = 0; m_done = 1;
         end else if (!m_busy && start) begin
            m_busy = 1; m_pool = cfg_pool_en; m_base = cfg_base_addr;
            m_rw = cfg_row_words; m_stride = cfg_row_stride;
            m_total = cfg_rows * cfg_row_words;
            m_acc = 0; m_xfer = 0; m_half = 0; m_ovf = 0;
         end
         if (pop) begin
            void'(q.pop_front());
            m_xfer++;
         end
         if (have) begin
            if (room) begin
               q.push_back(w);
               m_acc++;
            end else begin
               m_ovf = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      bit en_m;
      en_m = m_busy && (q.size() > 0);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("overflow", overflow, m_ovf);
      chk("wr_en", mem_wr_en, en_m);
      if (en_m) begin
         chk("wr_addr", mem_wr_addr, m_addr(m_xfer));
         chk("wr_data", mem_wr_data, q[0]);
      end
      if (!rst && mem_wr_en && mem_wr_ready) begin
         log_a.push_back(mem_wr_addr);
         log_d.push_back(mem_wr_data);
      end
      if (done) done_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_start(input logic pool, input logic [15:0] base, input logic [15:0] rw,
                           input logic [15:0] rows, input logic [15:0] stride);
      cfg_pool_en = pool; cfg_base_addr = base; cfg_row_words = rw;
      cfg_rows = rows; cfg_row_stride = stride;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic post_beat(input logic [63:0] d);
      post_out = d; post_out_valid = 1'b1;
      step();
      post_out_valid = 1'b0;
   endtask

   task automatic pool_beat(input logic [31:0] d);
      pooling_out = d; pooling_out_valid = 1'b1;
      step();
      pooling_out_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 300) begin
         step();
         n++;
      end
      chk("wait_done", done, 1'b1);
      step();
   endtask

   function automatic logic [63:0] rep4(input logic [15:0] h);
      return {h, h, h, h};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp_a [4];
      logic [15:0] a0;
      logic [63:0] d0;

      repeat (3) step();
      chk("rst_wr_en", mem_wr_en, 1'b0);
      chk("rst_addr", mem_wr_addr, 16'h0);
      chk("rst_data", mem_wr_data, 64'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      rst = 1'b0;
      step();

      // Post mode, 2x3 words, extra beats beyond the job and a start while busy.
      log_a.delete(); log_d.delete(); done_cnt = 0;
      do_start(1'b0, 16'h100, 16'd3, 16'd2, 16'd3);
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            start = 1'b1; cfg_base_addr = 16'h900;
         end
         post_beat(rep4(16'hA000 + 16'(i)));
         start = 1'b0;
      end
      wait_done();
      step(); step();
      chk("t1_count", log_a.size(), 6);
      for (int i = 0; i < 6; i++) chk("t1_addr", log_a[i], 16'h100 + 16'(i));
      chk("t1_data0", log_d[0], 64'hA000_A000_A000_A000);
      chk("t1_data5", log_d[5], 64'hA005_A005_A005_A005);
      chk("t1_done_pulses", done_cnt, 1);
      chk("t1_ovf", overflow, 1'b0);

      // Row stride addressing.
      log_a.delete(); log_d.delete();
`ifdef OUTPUT_WRITER_ROW_STRIDE_EN
      exp_a = '{16'h10, 16'h11, 16'h18, 16'h19};
`else
      exp_a = '{16'h10, 16'h11, 16'h12, 16'h13};
`endif
      do_start(1'b0, 16'h10, 16'd2, 16'd2, 16'd8);
      for (int i = 0; i < 4; i++) post_beat(rep4(16'hB000 + 16'(i)));
      wait_done();
      chk("t2_count", log_a.size(), 4);
      for (int i = 0; i < 4; i++) chk("t2_addr", log_a[i], exp_a[i]);

      // Pool mode packing, unselected stream ignored.
      log_a.delete(); log_d.delete();
      do_start(1'b1, 16'h40, 16'd1, 16'd1, 16'd0);
      pool_beat(32'h1111_1111);
      post_beat(64'hDEAD_BEEF_DEAD_BEEF);
      pool_beat(32'h2222_2222);
      pool_beat(32'h3333_3333);
      wait_done();
      chk("t3_count", log_a.size(), 1);
      chk("t3_data", log_d[0], 64'h2222_2222_1111_1111);
      chk("t3_addr", log_a[0], 16'h40);
      chk("t3_ovf", overflow, 1'b0);

      // Stall with overflow, then drain.
      log_a.delete(); log_d.delete();
      mem_wr_ready = 1'b0;
      do_start(1'b0, 16'h200, 16'd16, 16'd1, 16'd16);
      for (int i = 0; i < 10; i++) post_beat(rep4(16'hC000 + 16'(i)));
      a0 = mem_wr_addr; d0 = mem_wr_data;
      chk("t4_head_addr", a0, 16'h200);
      chk("t4_head_data", d0, 64'hC000_C000_C000_C000);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t4_stall_addr", mem_wr_addr, a0);
         chk("t4_stall_data", mem_wr_data, d0);
      end
      chk("t4_ovf", overflow, 1'b1);
      mem_wr_ready = 1'b1;
      repeat (10) step();
      for (int i = 10; i < 18; i++) post_beat(rep4(16'hC000 + 16'(i)));
      wait_done();
      chk("t4_count", log_a.size(), 16);
      chk("t4_data7", log_d[7], 64'hC007_C007_C007_C007);
      chk("t4_data8", log_d[8], 64'hC00A_C00A_C00A_C00A);
      chk("t4_addr15", log_a[15], 16'h20F);
      chk("t4_ovf_sticky", overflow, 1'b1);

      // Reset mid-job with queued words.
      log_a.delete(); log_d.delete();
      mem_wr_ready = 1'b0;
      do_start(1'b0, 16'h300, 16'd8, 16'd1, 16'd8);
      chk("t5_ovf_cleared", overflow, 1'b0);
      for (int i = 0; i < 3; i++) post_beat(rep4(16'hD000 + 16'(i)));
      chk("t5_wr_en_before", mem_wr_en, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("t5_rst_wr_en", mem_wr_en, 1'b0);
      chk("t5_rst_busy", busy, 1'b0);
      step();
      rst = 1'b0;
      mem_wr_ready = 1'b1;
      for (int i = 0; i < 3; i++) post_beat(rep4(16'hE000 + 16'(i)));
      repeat (10) step();
      chk("t5_no_writes", log_a.size(), 0);
      chk("t5_idle_wr_en", mem_wr_en, 1'b0);
      do_start(1'b0, 16'h500, 16'd1, 16'd1, 16'd1);
      post_beat(rep4(16'hF00D));
      wait_done();
      chk("t5_new_count", log_a.size(), 1);
      chk("t5_new_addr", log_a[0], 16'h500);
      chk("t5_new_data", log_d[0], 64'hF00D_F00D_F00D_F00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
